oumux_sched_2_5: RTL and testbench
==================================

OUMUX_SCHED_2_5 -- requirements
Module: oumux_sched_2_5

Interface
REQ-001 SHALL have parameter DW, default 512, the data beat width.
REQ-002 SHALL have parameter LENW, default 8, the beat-count field width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port cmd_valid, input, 1 bit: transfer command offered.
REQ-006 SHALL have port cmd_ready, output, 1 bit: command accepted when high together with cmd_valid.
REQ-007 SHALL have port cmd_dest, input, 3 bits: destination code 0..4, mapping to kernels k8, k9, k13, k14, k15.
REQ-008 SHALL have port cmd_len, input, LENW bits: number of beats; 0 encodes 2^LENW.
REQ-009 SHALL have port s_dat, input, DW bits: source data beat.
REQ-010 SHALL have port s_valid, input, 1 bit, and port s_ready, output, 1 bit: the source stream handshake.
REQ-011 SHALL have port d_dat, output, DW bits: broadcast data to all five destinations.
REQ-012 SHALL have port d_valid, output, 5 bits, and port d_ready, input, 5 bits: per-destination handshake, bit i = code i.
REQ-013 SHALL have port sel, output, 4 bits: registered select driven to the output mux.
REQ-014 SHALL have port abort, input, 1 bit: cancels the active transfer.
REQ-015 SHALL have ports busy, done, err, all outputs, 1 bit: busy = state XFER; done and err are 1-cycle pulses.
REQ-016 SHALL have port beat_cnt, output, 16 bits: total beats delivered since reset, wrapping.

Function
REQ-017 SHALL implement the states IDLE and XFER.
REQ-018 In IDLE, SHALL drive cmd_ready = 1 (0 while reset is high).
REQ-019 On cmd_valid and cmd_ready with cmd_dest <= 4, SHALL go to XFER at the next edge, load sel = {0,cmd_dest}, and load remaining = cmd_len (0 → 2^LENW).
REQ-020 On a command with cmd_dest >= 5, SHALL consume and drop it, stay in IDLE, pulse err next cycle, and leave sel unchanged.
REQ-021 In XFER, SHALL drive cmd_ready = 0.
REQ-022 SHALL drive d_dat = s_dat combinationally (zero latency).
REQ-023 SHALL drive d_valid[i] = XFER & (sel == i) & s_valid; all other bits 0.
REQ-024 SHALL drive s_ready = XFER & d_ready[sel]; d_ready bits of unselected destinations are ignored.
REQ-025 A beat is transferred when s_valid & s_ready; each beat SHALL decrement remaining and increment beat_cnt (wrapping 0xFFFF → 0x0000).
REQ-026 On the beat with remaining == 1, SHALL return to IDLE at the next edge and pulse done in that next cycle.
REQ-027 Timing: first beat possible one cycle after command acceptance; minimum command-to-command gap of one IDLE cycle.
REQ-028 SHALL hold sel at its last value in IDLE.
REQ-029 abort in XFER without a final beat in the same cycle SHALL return to IDLE next edge and pulse err; a non-final beat in that cycle still counts.
REQ-030 abort coincident with the final beat SHALL be ignored: done pulses and err does not.
REQ-031 abort in IDLE SHALL have no effect.
REQ-032 Stalls (s_valid=0 or d_ready[sel]=0) SHALL hold all state, with no timeout.

Reset
REQ-033 While reset is high, SHALL drive combinationally: d_valid = 0, s_ready = 0, cmd_ready = 0.
REQ-034 At the edge with reset high, SHALL set state = IDLE, sel = 0, remaining = 0, beat_cnt = 0, done = 0, err = 0, busy = 0.
REQ-035 Reset asserted mid-XFER SHALL drop the transfer with no done or err pulse.

Verification
REQ-036 Send cmd dest=3, len=4, with s_valid and d_ready all 1 → sel=3, d_valid=5'b01000 for 4 cycles, done on the 5th, beat_cnt=4.
REQ-037 Send cmd dest=1, len=3, and toggle d_ready[1] 1,0,1,0,1 while d_ready of other bits = 1 → exactly 3 beats, stalls honoured, s_ready follows d_ready[1] only.
REQ-038 Send cmd dest=6 → err pulse, state stays IDLE, sel unchanged, no d_valid.
REQ-039 Send cmd dest=0, len=5, and abort after 2 beats → err pulse, beat_cnt=2, cmd_ready=1 the next cycle; abort on the final beat → done only.
REQ-040 Send cmd len=0 → 256 beats delivered; preload beat_cnt near 0xFFFF via traffic and check it wraps to 0.
REQ-041 Assert reset mid-transfer after 2 of 8 beats → d_valid=0 immediately, all registers at reset values, no done or err; the next command runs normally.

Source files
------------

// File: rtl/oumux_sched_2_5.sv
// oumux_sched_2_5
// Routes a single source stream to one of five destination kernels
// (codes 0..4 -> k8, k9, k13, k14, k15). Each transfer is set up by a command
// and lasts a fixed number of beats.
//
// Ports
//   clk, reset        : single clock; synchronous active-high reset
//   cmd_valid/ready   : command handshake. cmd_dest selects the destination code;
//                       cmd_len gives the beat count, where 0 means 2^LENW beats
//   s_dat/valid/ready : source stream
//   d_dat             : source data broadcast to every destination, no latency
//   d_valid/d_ready   : per-destination handshake, bit i belongs to code i
//   sel               : registered select for the output mux; holds its value in IDLE
//   abort             : cancels the active transfer
//   busy              : high while a transfer is active
//   done, err         : single-cycle status pulses
//   beat_cnt          : wrapping count of beats delivered since reset
module oumux_sched_2_5 #(
  parameter int DW   = 512,
  parameter int LENW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [2:0]      cmd_dest,
  input  logic [LENW-1:0] cmd_len,
  input  logic [DW-1:0]   s_dat,
  input  logic            s_valid,
  output logic            s_ready,
  output logic [DW-1:0]   d_dat,
  output logic [4:0]      d_valid,
  input  logic [4:0]      d_ready,
  output logic [3:0]      sel,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [15:0]     beat_cnt
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t          state_r;
  state_t          state_nx_s;
  // One bit wider than cmd_len so that 2^LENW beats can be represented.
  logic [LENW:0]   remaining_r;
  logic [LENW:0]   remaining_nx_s;
  logic [3:0]      sel_r;
  logic [3:0]      sel_nx_s;
  logic [15:0]     beat_cnt_r;
  logic            done_r;
  logic            err_r;
  logic            busy_r;
  logic            done_nx_s;
  logic            err_nx_s;
  logic [4:0]      sel_oh_s;
  logic            xfer_s;
  logic            beat_s;
  logic            last_s;
  logic            cmd_acc_s;
  logic            dest_ok_s;

  // Handshake decode. Reset gates every combinational handshake output.
  always_comb begin
    sel_oh_s = 5'd0;
    if (sel_r < 4'd5) begin
      sel_oh_s = 5'd1 << sel_r;
    end else begin
      sel_oh_s = 5'd0;
    end
    xfer_s    = (state_r == XFER) && !reset;
    cmd_ready = (state_r == IDLE) && !reset;
    // Only the selected destination's ready is looked at.
    s_ready   = xfer_s && ((d_ready & sel_oh_s) != 5'd0);
    d_valid   = (xfer_s && s_valid) ? sel_oh_s : 5'd0;
    beat_s    = s_valid && s_ready;
    last_s    = beat_s && (remaining_r == {{LENW{1'b0}}, 1'b1});
    cmd_acc_s = cmd_valid && cmd_ready;
    dest_ok_s = (cmd_dest <= 3'd4);
  end

  // Next-state logic and transfer bookkeeping.
  always_comb begin
    state_nx_s     = state_r;
    sel_nx_s       = sel_r;
    remaining_nx_s = remaining_r;
    done_nx_s      = 1'b0;
    err_nx_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (cmd_acc_s && dest_ok_s) begin
          state_nx_s     = XFER;
          sel_nx_s       = {1'b0, cmd_dest};
          remaining_nx_s = (cmd_len == {LENW{1'b0}}) ? {1'b1, {LENW{1'b0}}}
                                                     : {1'b0, cmd_len};
        end else if (cmd_acc_s) begin
          // A bad destination code is consumed and dropped; sel keeps its value.
          err_nx_s = 1'b1;
        end else begin
          state_nx_s = IDLE;
        end
      end
      XFER: begin
        if (beat_s) begin
          remaining_nx_s = remaining_r - {{LENW{1'b0}}, 1'b1};
        end else begin
          remaining_nx_s = remaining_r;
        end
        // The final beat wins over a coincident abort.
        if (last_s) begin
          state_nx_s = IDLE;
          done_nx_s  = 1'b1;
        end else if (abort) begin
          state_nx_s = IDLE;
          err_nx_s   = 1'b1;
        end else begin
          state_nx_s = XFER;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Select, beat budget, status pulses and the running beat counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_r       <= 4'd0;
      remaining_r <= {(LENW+1){1'b0}};
      beat_cnt_r  <= 16'd0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      sel_r       <= sel_nx_s;
      remaining_r <= remaining_nx_s;
      done_r      <= done_nx_s;
      err_r       <= err_nx_s;
      busy_r      <= (state_nx_s == XFER);
      if (beat_s) begin
        beat_cnt_r <= beat_cnt_r + 16'd1;
      end else begin
        beat_cnt_r <= beat_cnt_r;
      end
    end
  end

  assign d_dat    = s_dat;
  assign sel      = sel_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign err      = err_r;
  assign beat_cnt = beat_cnt_r;

endmodule

// File: tb/tb_oumux_sched_2_5.sv
// tb_oumux_sched_2_5
// Self-checking bench for oumux_sched_2_5. A cycle-level reference model,
// written directly from the transfer rules using integers, predicts every
// output. Directed scenarios add explicit constant checks. These are followed
// by a randomized phase and by a long run that drives beat_cnt through its wrap.
module tb_oumux_sched_2_5;
  localparam int DW   = 512;
  localparam int LENW = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [2:0]      cmd_dest;
  logic [LENW-1:0] cmd_len;
  logic [DW-1:0]   s_dat;
  logic            s_valid;
  logic            s_ready;
  logic [DW-1:0]   d_dat;
  logic [4:0]      d_valid;
  logic [4:0]      d_ready;
  logic [3:0]      sel;
  logic            abort;
  logic            busy;
  logic            done;
  logic            err;
  logic [15:0]     beat_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Reference model state
  int m_busy = 0;
  int m_sel  = 0;
  int m_rem  = 0;
  int m_cnt  = 0;
  int m_done = 0;
  int m_err  = 0;

  always #5 clk = ~clk;

  oumux_sched_2_5 #(.DW(DW), .LENW(LENW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dest(cmd_dest), .cmd_len(cmd_len),
    .s_dat(s_dat), .s_valid(s_valid), .s_ready(s_ready),
    .d_dat(d_dat), .d_valid(d_valid), .d_ready(d_ready),
    .sel(sel), .abort(abort),
    .busy(busy), .done(done), .err(err),
    .beat_cnt(beat_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Compare every output against the model before the edge is applied.
  task automatic check_all();
    logic [4:0] ev;
    logic       er;
    ev = 5'd0;
    if (!reset && m_busy != 0 && s_valid) ev = 5'(1 << m_sel);
    er = !reset && (m_busy != 0) && d_ready[m_sel];
    chk("d_valid",   32'(d_valid),   32'(ev));
    chk("s_ready",   32'(s_ready),   32'(er));
    chk("cmd_ready", 32'(cmd_ready), 32'(!reset && m_busy == 0));
    chk("sel",       32'(sel),       32'(m_sel));
    chk("busy",      32'(busy),      32'(m_busy));
    chk("done",      32'(done),      32'(m_done));
    chk("err",       32'(err),       32'(m_err));
    chk("beat_cnt",  32'(beat_cnt),  32'(m_cnt));
    chk("d_dat",     32'(d_dat === s_dat), 32'd1);
  endtask

  // Advance the model by one clock using the current inputs.
  task automatic model_step();
    int beat;
    beat   = (m_busy != 0 && s_valid && d_ready[m_sel]) ? 1 : 0;
    m_done = 0;
    m_err  = 0;
    if (reset) begin
      m_busy = 0; m_sel = 0; m_rem = 0; m_cnt = 0;
    end else if (m_busy == 0) begin
      if (cmd_valid) begin
        if (cmd_dest <= 3'd4) begin
          m_busy = 1;
          m_sel  = int'(cmd_dest);
          m_rem  = (cmd_len == 8'd0) ? (1 << LENW) : int'(cmd_len);
        end else begin
          m_err = 1;
        end
      end
    end else begin
      if (beat != 0) begin
        m_cnt = (m_cnt + 1) % 65536;
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          m_busy = 0;
          m_done = 1;
        end
      end
      if (m_busy != 0 && abort) begin
        m_busy = 0;
        m_err  = 1;
      end
    end
  endtask

  // One clock: check at the falling edge, step the model, and return 1 ns after the rising edge.
  task automatic cycle();
    @(negedge clk);
    if (chk_en) check_all();
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_dest = 3'd0; cmd_len = 8'd0;
    s_dat = {16{$urandom()}}; s_valid = 1'b0; d_ready = 5'd0; abort = 1'b0;
    cycle();
    chk_en = 1'b1;
    // Reset state
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_sel",       32'(sel),       32'd0);
    chk("rst_cnt",       32'(beat_cnt),  32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    cycle();
    reset = 1'b0;
    cycle();

    // dest 3, len 4, free-flowing
    cmd_valid = 1'b1; cmd_dest = 3'd3; cmd_len = 8'd4; s_valid = 1'b1; d_ready = 5'h1f;
    cycle();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t1_dvalid", 32'(d_valid), 32'h08);
      chk("t1_sel",    32'(sel),     32'd3);
      cycle();
    end
    chk("t1_done", 32'(done),     32'd1);
    chk("t1_cnt",  32'(beat_cnt), 32'd4);

    // dest 1, len 3, d_ready[1] toggled 1,0,1,0,1
    cmd_valid = 1'b1; cmd_dest = 3'd1; cmd_len = 8'd3;
    cycle();
    cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      d_ready = {3'b111, ((i % 2) == 0), 1'b1};
      #1;
      chk("t2_sready", 32'(s_ready), 32'((i % 2) == 0));
      cycle();
    end
    chk("t2_done", 32'(done),     32'd1);
    chk("t2_cnt",  32'(beat_cnt), 32'd7);
    d_ready = 5'h1f;

    // bad destination 6
    cmd_valid = 1'b1; cmd_dest = 3'd6; cmd_len = 8'd2;
    cycle();
    cmd_valid = 1'b0;
    chk("t3_err",    32'(err),       32'd1);
    chk("t3_busy",   32'(busy),      32'd0);
    chk("t3_sel",    32'(sel),       32'd1);
    chk("t3_dvalid", 32'(d_valid),   32'd0);
    cycle();

    // abort after 2 beats
    cmd_valid = 1'b1; cmd_dest = 3'd0; cmd_len = 8'd5;
    cycle();
    cmd_valid = 1'b0;
    cycle(); cycle();
    s_valid = 1'b0; abort = 1'b1;
    cycle();
    abort = 1'b0;
    chk("t4_err",       32'(err),       32'd1);
    chk("t4_done",      32'(done),      32'd0);
    chk("t4_cnt",       32'(beat_cnt),  32'd9);
    chk("t4_cmd_ready", 32'(cmd_ready), 32'd1);
    cycle();
    // abort coincident with the final beat
    cmd_valid = 1'b1; cmd_dest = 3'd0; cmd_len = 8'd2;
    cycle();
    cmd_valid = 1'b0; s_valid = 1'b1;
    cycle();
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    chk("t4b_done", 32'(done),     32'd1);
    chk("t4b_err",  32'(err),      32'd0);
    chk("t4b_cnt",  32'(beat_cnt), 32'd11);
    cycle();

    // reset mid-transfer after 2 of 8 beats
    cmd_valid = 1'b1; cmd_dest = 3'd2; cmd_len = 8'd8;
    cycle();
    cmd_valid = 1'b0;
    cycle(); cycle();
    reset = 1'b1;
    #1;
    chk("t5_dvalid",    32'(d_valid),   32'd0);
    chk("t5_sready",    32'(s_ready),   32'd0);
    chk("t5_cmd_ready", 32'(cmd_ready), 32'd0);
    cycle();
    reset = 1'b0;
    chk("t5_busy", 32'(busy),     32'd0);
    chk("t5_sel",  32'(sel),      32'd0);
    chk("t5_cnt",  32'(beat_cnt), 32'd0);
    chk("t5_done", 32'(done),     32'd0);
    chk("t5_err",  32'(err),      32'd0);
    cycle();
    chk("t5_done2", 32'(done), 32'd0);
    chk("t5_err2",  32'(err),  32'd0);
    cmd_valid = 1'b1; cmd_dest = 3'd4; cmd_len = 8'd2;
    cycle();
    cmd_valid = 1'b0;
    cycle(); cycle();
    chk("t5_next_done", 32'(done),     32'd1);
    chk("t5_next_cnt",  32'(beat_cnt), 32'd2);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 99) == 0);
      abort     = ($urandom_range(0, 19) == 0);
      cmd_valid = ($urandom_range(0, 2) == 0);
      cmd_dest  = 3'($urandom_range(0, 7));
      cmd_len   = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 6));
      s_valid   = ($urandom_range(0, 3) != 0);
      d_ready   = 5'($urandom_range(0, 31));
      s_dat     = {16{$urandom()}};
      cycle();
    end

    // fill beat_cnt to 0xFF00 with 255 full-length transfers, then cross the wrap
    reset = 1'b1; abort = 1'b0; cmd_valid = 1'b0; s_valid = 1'b1; d_ready = 5'h1f;
    cycle();
    reset = 1'b0;
    cmd_dest = 3'd0; cmd_len = 8'd0;
    chk_en = 1'b0;
    for (int c = 0; c < 255; c++) begin
      cmd_valid = 1'b1;
      cycle();
      cmd_valid = 1'b0;
      for (int b = 0; b < 256; b++) cycle();
    end
    chk_en = 1'b1;
    chk("fill_cnt", 32'(beat_cnt), 32'hff00);
    cmd_valid = 1'b1;
    cycle();
    cmd_valid = 1'b0;
    for (int b = 0; b < 255; b++) cycle();
    chk("pre_wrap_cnt",  32'(beat_cnt), 32'hffff);
    chk("pre_wrap_busy", 32'(busy),     32'd1);
    cycle();
    chk("wrap_cnt",  32'(beat_cnt), 32'd0);
    chk("wrap_done", 32'(done),     32'd1);
    chk("wrap_busy", 32'(busy),     32'd0);
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
